// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback,
// waits on memory ready handshakes, traps on illegal encodings or timeouts.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32,
  parameter bit FUNCT3_CHECK   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             InstructionRead,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             Regwrite,
  output logic             MemRead,
  output logic             Memorywrite,
  output logic             ALUSrcA,
  output logic             Mux_ALU_rs2,
  output logic [1:0]       ALUOp,
  output logic [1:0]       WBSel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int TCW     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int TO_SAT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t           r_state;
  logic [6:0]       r_opcode;
  logic [TCW-1:0]   r_tcnt;
  logic             r_trap;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_cnt;

  logic           w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
  logic           w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;
  logic           w_legal, w_to_hit, w_retire;
  logic [TCW-1:0] w_tcnt_inc;

  function automatic logic legal_instr(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: ok = 1'b1;
      OP_LOAD:  ok = !FUNCT3_CHECK || !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      OP_STORE: ok = !FUNCT3_CHECK || (f3 <= 3'b010);
      OP_BR:    ok = !FUNCT3_CHECK || !(f3 == 3'b010 || f3 == 3'b011);
      OP_JALR:  ok = !FUNCT3_CHECK || (f3 == 3'b000);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Class decodes come from the opcode latched in DECODE, so the instruction
  // register is free to change once decode is done.
  assign w_is_r     = (r_opcode == OP_R);
  assign w_is_i     = (r_opcode == OP_I);
  assign w_is_ld    = (r_opcode == OP_LOAD);
  assign w_is_st    = (r_opcode == OP_STORE);
  assign w_is_br    = (r_opcode == OP_BR);
  assign w_is_jal   = (r_opcode == OP_JAL);
  assign w_is_jalr  = (r_opcode == OP_JALR);
  assign w_is_lui   = (r_opcode == OP_LUI);
  assign w_is_auipc = (r_opcode == OP_AUIPC);

  assign w_legal    = legal_instr(opcode, funct3);
  assign w_to_hit   = (TIMEOUT_CYCLES != 0) && (r_tcnt == TCW'(TO_LAST));
  assign w_tcnt_inc = (r_tcnt == TCW'(TO_SAT)) ? r_tcnt : r_tcnt + TCW'(1);

  assign w_retire = ((r_state == S_EXECUTE) && w_is_br) ||
                    ((r_state == S_MEM) && w_is_st && dmem_ready) ||
                    (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_tcnt  <= '0;
      r_trap  <= 1'b0;
      r_cause <= 2'b00;
      r_cnt   <= '0;
    end else begin
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_state <= S_DECODE;
            r_tcnt  <= '0;
          end else if (w_to_hit) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= 2'b10;
            r_tcnt  <= '0;
          end else begin
            r_tcnt <= w_tcnt_inc;
          end
        end
        S_DECODE: begin
          r_tcnt <= '0;
          if (w_legal) begin
            r_state <= S_EXECUTE;
          end else begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= 2'b01;
          end
        end
        S_EXECUTE: begin
          r_tcnt <= '0;
          if (w_is_br)                r_state <= S_FETCH;
          else if (w_is_ld || w_is_st) r_state <= S_MEM;
          else                        r_state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_state <= w_is_ld ? S_WB : S_FETCH;
            r_tcnt  <= '0;
          end else if (w_to_hit) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= 2'b11;
            r_tcnt  <= '0;
          end else begin
            r_tcnt <= w_tcnt_inc;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_tcnt  <= '0;
        end
        S_TRAP: begin
          r_state <= S_TRAP;
        end
        default: begin
          r_state <= S_FETCH;
          r_tcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) r_opcode <= opcode;
  end

  logic       w_ir, w_pcw, w_rw, w_mr, w_mw, w_asrc, w_rs2;
  logic [1:0] w_pcsel, w_aluop, w_wbsel;

  always_comb begin
    w_ir    = 1'b0;
    w_pcw   = 1'b0;
    w_pcsel = 2'b00;
    w_rw    = 1'b0;
    w_mr    = 1'b0;
    w_mw    = 1'b0;
    w_asrc  = 1'b0;
    w_rs2   = 1'b0;
    w_aluop = 2'b00;
    w_wbsel = 2'b00;
    case (r_state)
      S_FETCH: w_ir = 1'b1;
      S_EXECUTE: begin
        if (w_is_r) begin
          w_rs2   = 1'b1;
          w_aluop = 2'b10;
        end
        if (w_is_i)     w_aluop = 2'b10;
        if (w_is_auipc) w_asrc  = 1'b1;
        if (w_is_br) begin
          w_rs2   = 1'b1;
          w_aluop = 2'b01;
          w_pcw   = 1'b1;
          w_pcsel = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        // PC advances only on the completing cycle of a store, never while stalled.
        w_mr  = w_is_ld;
        w_mw  = w_is_st;
        w_pcw = w_is_st && dmem_ready;
      end
      S_WB: begin
        w_rw  = 1'b1;
        w_pcw = 1'b1;
        if (w_is_jal)       w_pcsel = 2'b01;
        else if (w_is_jalr) w_pcsel = 2'b10;
        if (w_is_ld)                    w_wbsel = 2'b01;
        else if (w_is_jal || w_is_jalr) w_wbsel = 2'b10;
        else if (w_is_lui)              w_wbsel = 2'b11;
      end
      default: ;
    endcase
  end

  assign InstructionRead = rst_n & w_ir;
  assign PCWrite         = rst_n & w_pcw;
  assign PCSel           = rst_n ? w_pcsel : 2'b00;
  assign Regwrite        = rst_n & w_rw;
  assign MemRead         = rst_n & w_mr;
  assign Memorywrite     = rst_n & w_mw;
  assign ALUSrcA         = rst_n & w_asrc;
  assign Mux_ALU_rs2     = rst_n & w_rs2;
  assign ALUOp           = rst_n ? w_aluop : 2'b00;
  assign WBSel           = rst_n ? w_wbsel : 2'b00;
  assign trap            = rst_n & r_trap;
  assign trap_cause      = rst_n ? r_cause : 2'b00;
  assign retired         = rst_n ? r_cnt : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (default parameters and a
// short-timeout / 4-bit counter / no-funct3-check variant) against a phase model.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_T = 5, PH_RST = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n_a = '0;
  logic [1:0]  im_a = '0;
  logic [1:0]  dm_a = '0;
  logic [1:0]  tk_a = '0;
  logic [6:0]  op_a [2];
  logic [2:0]  f3_a [2];
  logic [15:0] ctl_a [2];
  logic [31:0] ret_a [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cnt_m [2];
  logic [6:0]  legal_ops [9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CW = (g == 0) ? 32 : 4;
    logic ir, pcw, rw, mr, mw, asrc, rs2, tr;
    logic [1:0] pcsel, aluop, wbsel, cause;
    logic [CW-1:0] ret;
    multicycle_control #(
      .TIMEOUT_CYCLES((g == 0) ? 15 : 4),
      .CNT_W(CW),
      .FUNCT3_CHECK((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n_a[g]), .opcode(op_a[g]), .funct3(f3_a[g]),
      .branch_taken(tk_a[g]), .imem_ready(im_a[g]), .dmem_ready(dm_a[g]),
      .InstructionRead(ir), .PCWrite(pcw), .PCSel(pcsel), .Regwrite(rw),
      .MemRead(mr), .Memorywrite(mw), .ALUSrcA(asrc), .Mux_ALU_rs2(rs2),
      .ALUOp(aluop), .WBSel(wbsel), .trap(tr), .trap_cause(cause), .retired(ret)
    );
    assign ctl_a[g] = {ir, pcw, pcsel, rw, mr, mw, asrc, rs2, aluop, wbsel, tr, cause};
    assign ret_a[g] = 32'(ret);
  end

  function automatic int to_of(input int d);
    return (d == 0) ? 15 : 4;
  endfunction

  function automatic bit chk_of(input int d);
    return (d == 0);
  endfunction

  function automatic logic [31:0] cmask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input bit chk);
    case (op)
      OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
      OP_LD:   return !chk || !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      OP_ST:   return !chk || (f3 <= 3'b010);
      OP_BR:   return !chk || !(f3 == 3'b010 || f3 == 3'b011);
      OP_JALR: return !chk || (f3 == 3'b000);
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word for one cycle of a given phase of instruction op.
  function automatic logic [15:0] expect_ctl(input int ph, input logic [6:0] op,
                                             input logic tk, input logic dm, input logic [1:0] cause);
    logic ir, pcw, rw, mr, mw, asrc, rs2, tr;
    logic [1:0] pcsel, aluop, wbsel, c;
    {ir, pcw, rw, mr, mw, asrc, rs2, tr} = '0;
    {pcsel, aluop, wbsel, c} = '0;
    case (ph)
      PH_F: ir = 1'b1;
      PH_E: begin
        if (op == OP_R)     begin rs2 = 1'b1; aluop = 2'b10; end
        if (op == OP_I)     aluop = 2'b10;
        if (op == OP_AUIPC) asrc = 1'b1;
        if (op == OP_BR)    begin rs2 = 1'b1; aluop = 2'b01; pcw = 1'b1; pcsel = {1'b0, tk}; end
      end
      PH_M: begin
        mr  = (op == OP_LD);
        mw  = (op == OP_ST);
        pcw = (op == OP_ST) && dm;
      end
      PH_W: begin
        rw = 1'b1; pcw = 1'b1;
        pcsel = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
        wbsel = (op == OP_LD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 :
                (op == OP_LUI) ? 2'd3 : 2'd0;
      end
      PH_T: begin tr = 1'b1; c = cause; end
      default: ;
    endcase
    return {ir, pcw, pcsel, rw, mr, mw, asrc, rs2, aluop, wbsel, tr, c};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Drive one cycle, check at the falling edge, then step past the rising edge.
  task automatic cyc(input int d, input int ph, input logic rst, input logic im, input logic dm,
                     input logic tk, input logic [6:0] bop, input logic [2:0] bf3,
                     input logic [6:0] mop, input logic [1:0] cause);
    logic [15:0] e;
    logic [31:0] er;
    rst_n_a[d] = rst; im_a[d] = im; dm_a[d] = dm; tk_a[d] = tk;
    op_a[d] = bop; f3_a[d] = bf3;
    @(negedge clk);
    e  = rst ? expect_ctl(ph, mop, tk, dm, cause) : 16'h0000;
    er = rst ? (32'(cnt_m[d]) & cmask(d)) : 32'h0;
    n_vec++;
    assert (ctl_a[d] === e) else begin
      n_err++;
      $error("FAIL ctl dut%0d ph%0d op=%b: observed %h expected %h", d, ph, mop, ctl_a[d], e);
    end
    n_vec++;
    assert (ret_a[d] === er) else begin
      n_err++;
      $error("FAIL retired dut%0d ph%0d: observed %0d expected %0d", d, ph, ret_a[d], er);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d, input int n);
    for (int j = 0; j < n; j++)
      cyc(d, PH_RST, 1'b0, 1'b1, rb(), rb(), 7'($urandom), 3'($urandom), 7'h00, 2'b00);
    cnt_m[d] = 0;
  endtask

  // Run one instruction: wi not-ready fetch cycles, wd not-ready memory cycles.
  task automatic run_instr(input int d, input logic [6:0] op, input logic [2:0] f3,
                           input logic tk, input int wi, input int wd);
    int to, k;
    bit trapped, fin, rdy;
    logic [1:0] tc;
    to = to_of(d); trapped = 0; fin = 0; tc = 2'b00;
    k = 0;
    while (1) begin
      rdy = (k == wi);
      cyc(d, PH_F, 1'b1, rdy, rb(), rb(), 7'($urandom), 3'($urandom), op, 2'b00);
      if (rdy) break;
      if (to != 0 && k + 1 == to) begin trapped = 1; tc = 2'b10; break; end
      k++;
    end
    if (!trapped) begin
      cyc(d, PH_D, 1'b1, rb(), rb(), rb(), op, f3, op, 2'b00);
      if (!is_legal(op, f3, chk_of(d))) begin trapped = 1; tc = 2'b01; end
    end
    if (!trapped) begin
      cyc(d, PH_E, 1'b1, rb(), rb(), tk, 7'($urandom), 3'($urandom), op, 2'b00);
      if (op == OP_BR) begin cnt_m[d]++; fin = 1; end
    end
    if (!trapped && !fin && (op == OP_LD || op == OP_ST)) begin
      k = 0;
      while (1) begin
        rdy = (k == wd);
        cyc(d, PH_M, 1'b1, rb(), rdy, rb(), 7'($urandom), 3'($urandom), op, 2'b00);
        if (rdy) begin
          if (op == OP_ST) begin cnt_m[d]++; fin = 1; end
          break;
        end
        if (to != 0 && k + 1 == to) begin trapped = 1; tc = 2'b11; break; end
        k++;
      end
    end
    if (!trapped && !fin) begin
      cyc(d, PH_W, 1'b1, rb(), rb(), rb(), 7'($urandom), 3'($urandom), op, 2'b00);
      cnt_m[d]++;
    end
    if (trapped) begin
      for (int j = 0; j < 3; j++)
        cyc(d, PH_T, 1'b1, 1'b1, rb(), rb(), 7'($urandom), 3'($urandom), op, tc);
      do_reset(d, $urandom_range(1, 3));
    end
  endtask

  initial begin
    logic [6:0] rop;
    int wi, wd;
    op_a[0] = '0; op_a[1] = '0; f3_a[0] = '0; f3_a[1] = '0;
    cnt_m[0] = 0; cnt_m[1] = 0;

    // Directed checks on the default instance
    do_reset(0, 3);
    run_instr(0, OP_R, 3'b000, 1'b0, 0, 0);
    run_instr(0, OP_LD, 3'b010, 1'b0, 0, 3);
    run_instr(0, OP_BR, 3'b000, 1'b1, 0, 0);
    run_instr(0, OP_BR, 3'b001, 1'b0, 1, 0);
    run_instr(0, OP_ST, 3'b010, 1'b0, 0, 2);
    run_instr(0, OP_JAL, 3'b000, 1'b0, 0, 0);
    run_instr(0, OP_JALR, 3'b000, 1'b0, 0, 0);
    run_instr(0, OP_LUI, 3'b000, 1'b0, 0, 0);
    run_instr(0, OP_AUIPC, 3'b000, 1'b0, 0, 0);
    run_instr(0, OP_I, 3'b000, 1'b0, 14, 0);
    // Abort an add with reset in its writeback cycle
    cyc(0, PH_F, 1'b1, 1'b1, 1'b0, 1'b0, 7'h00, 3'b000, OP_R, 2'b00);
    cyc(0, PH_D, 1'b1, 1'b0, 1'b0, 1'b0, OP_R, 3'b000, OP_R, 2'b00);
    cyc(0, PH_E, 1'b1, 1'b0, 1'b0, 1'b0, OP_R, 3'b000, OP_R, 2'b00);
    do_reset(0, 1);
    run_instr(0, 7'b1111111, 3'b000, 1'b0, 0, 0);
    run_instr(0, OP_LD, 3'b011, 1'b0, 0, 0);
    run_instr(0, OP_JALR, 3'b001, 1'b0, 0, 0);
    run_instr(0, OP_R, 3'b000, 1'b0, 15, 0);
    run_instr(0, OP_LD, 3'b000, 1'b0, 0, 15);
    run_instr(0, OP_ST, 3'b000, 1'b0, 0, 14);

    // Directed checks on the short-timeout, no-funct3-check instance
    do_reset(1, 2);
    run_instr(1, OP_LD, 3'b011, 1'b0, 0, 0);
    run_instr(1, OP_R, 3'b000, 1'b0, 4, 0);
    run_instr(1, OP_R, 3'b000, 1'b0, 3, 0);
    run_instr(1, OP_ST, 3'b111, 1'b0, 0, 3);
    run_instr(1, OP_ST, 3'b000, 1'b0, 0, 4);
    for (int i = 0; i < 17; i++) run_instr(1, OP_R, 3'b000, 1'b0, 0, 0);
    run_instr(1, OP_LUI, 3'b000, 1'b0, 0, 0);

    // Randomized instruction streams on both instances
    for (int d = 0; d < 2; d++) begin
      do_reset(d, 2);
      for (int i = 0; i < 150; i++) begin
        rop = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
        wi  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, to_of(d) + 1)) : int'($urandom_range(0, 2));
        wd  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, to_of(d) + 1)) : int'($urandom_range(0, 2));
        run_instr(d, rop, 3'($urandom), rb(), wi, wd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and waits on ready handshakes from instruction and data memory. It also detects illegal encodings and memory timeouts, and counts retired instructions. It sits between the instruction register / ALU compare logic and the datapath muxes, PC register, register file and memory ports.

## Interface
- TIMEOUT_CYCLES, 15: consecutive not-ready cycles in FETCH or MEM before a timeout trap; 0 disables timeouts.
- CNT_W, 32: width of the retired-instruction counter.
- FUNCT3_CHECK, 1: 1 = reject reserved funct3 values for load/store/branch/JALR; 0 = check opcode only.
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  7  instr[6:0]; valid from DECODE onward.
- funct3  in  3  instr[14:12]; valid from DECODE onward.
- branch_taken  in  1  ALU compare result; sampled in EXECUTE.
- imem_ready  in  1  instruction memory has returned the word.
- dmem_ready  in  1  data memory access is complete.
- InstructionRead  out  1  instruction fetch request.
- PCWrite  out  1  PC register load enable.
- PCSel  out  2  PC source: 0 pc+4, 1 pc+imm, 2 ALU result.
- Regwrite  out  1  register file write enable.
- MemRead  out  1  data memory read request.
- Memorywrite  out  1  data memory write request.
- ALUSrcA  out  1  ALU A input: 0 rs1, 1 PC.
- Mux_ALU_rs2  out  1  ALU B input: 1 rs2, 0 immediate.
- ALUOp  out  2  00 add, 01 branch compare, 10 funct decode.
- WBSel  out  2  writeback source: 0 ALU, 1 memory, 2 pc+4, 3 immediate.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  01 illegal instruction, 10 fetch timeout, 11 data timeout.
- retired  out  CNT_W  count of completed instructions.

## Operation
- States:
  - FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
  - State register, opcode/funct3 latch, timeout counter, trap regs and retire counter are all flops.
  - All other outputs are Moore decodes of state and the latched opcode.
- FETCH: InstructionRead=1.
  - imem_ready=1 -> DECODE.
  - Otherwise the timeout counter increments; when it reaches TIMEOUT_CYCLES -> TRAP with cause 10.
- DECODE: capture opcode/funct3 into internal regs.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - With FUNCT3_CHECK=1, these are illegal: load funct3 011/110/111; store funct3 >010; branch 010/011; JALR funct3 ≠000.
  - Legal -> EXECUTE; illegal -> TRAP with cause 01.
- EXECUTE, per opcode:
  - R-type (0110011): Mux_ALU_rs2=1, ALUOp=10.
  - I-ALU (0010011): imm, ALUOp=10.
  - Load/store: imm, ALUOp=00 -> MEM.
  - AUIPC: ALUSrcA=1, imm, ALUOp=00.
  - Branch: ALUOp=01, PCWrite=1, PCSel = branch_taken ? 1 : 0 -> FETCH (retires).
  - All other legal opcodes -> WRITEBACK.
- MEM: load drives MemRead=1, store drives Memorywrite=1, held until dmem_ready.
  - Load -> WRITEBACK.
  - Store: PCWrite=1, PCSel=0 -> FETCH (retires).
  - Timeout handling as in FETCH, with cause 11.
- WRITEBACK: Regwrite=1, PCWrite=1 -> FETCH (retires).
  - PCSel: 1 for JAL, 2 for JALR, 0 otherwise.
  - WBSel: 1 for load, 2 for JAL/JALR, 3 for LUI, 0 otherwise.
- TRAP: absorbing. trap=1, all enables 0, cause frozen. Left only by reset.
- Timeout counter:
  - Clears on every state entry.
  - Saturates at TIMEOUT_CYCLES; width is clog2(TIMEOUT_CYCLES+1), minimum 1.
- Retire counter: +1 on each retiring cycle; wraps modulo 2^CNT_W.

## Timing
- Reset: with rst_n=0 at a clk edge, state=FETCH and counters, trap and trap_cause = 0.
- While rst_n=0, every output is forced to 0, including InstructionRead.
- Reset mid-instruction aborts it: no Regwrite/PCWrite, and retired does not increment.
- Latency, with ready asserted on the first cycle:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle adds one.
- Handshake: a request stays high until ready is sampled high. Ready is ignored in other states.
- Ready=1 in the same cycle the counter would hit the limit: ready wins, no trap.
- TIMEOUT_CYCLES=N: trap is entered on the edge after the N-th consecutive not-ready cycle. trap is visible the cycle after that.
- retired updates on the edge that ends the retiring cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with imem_ready=1 -> all outputs 0. First cycle after release: InstructionRead=1, retired=0.
- add (0110011), ready always 1 -> cycle 4 has Regwrite=1, PCWrite=1, PCSel=0, WBSel=0; retired=1 afterwards.
- lw with dmem_ready low for 3 cycles -> MemRead high for 4 cycles, then WRITEBACK with WBSel=1; 8 cycles total.
- beq with branch_taken=1 -> PCWrite=1, PCSel=1 in cycle 3, Regwrite never asserted. With branch_taken=0 -> PCSel=0.
- Illegal inputs -> trap=1, cause 01, no further InstructionRead until reset:
  - opcode 1111111;
  - load with funct3=011 and FUNCT3_CHECK=1.
  - With FUNCT3_CHECK=0, the same load proceeds normally.
- TIMEOUT_CYCLES=4 with imem_ready held 0 -> trap, cause 10, after 4 wait cycles. With imem_ready=1 on wait cycle 4 -> DECODE, no trap. With CNT_W=4 and 17 retirements -> retired=1.
